// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the MEM stage:
// access-width codes, byte-enable generation and alignment check.
package mem_pkg;

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;

    // Width code 2'b11 is handled as a full word.
    function automatic logic [3:0] byte_enable(input logic [1:0] width, input logic [1:0] lane);
        case (width)
            WIDTH_BYTE: return 4'b0001 << lane;
            WIDTH_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            default:    return 4'b1111;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [1:0] width, input logic [1:0] lane);
        case (width)
            WIDTH_BYTE: return 1'b1;
            WIDTH_HALF: return ~lane[0];
            default:    return (lane == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/data_memory.sv
// Word-organised data RAM with per-byte write enables, asynchronous clear,
// and two combinational read ports (pipeline and debug).
module data_memory #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [3:0]            i_byte_en,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata,
    input  logic [ADDR_WIDTH-1:0] i_debug_addr,
    output logic [31:0]           o_debug_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (i_byte_en[b]) begin
                    mem_q[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata      = mem_q[i_addr];
    assign o_debug_data = mem_q[i_debug_addr];

endmodule

// File: rtl/memory_access.sv
// MIPS MEM stage: alignment check, byte/half/word store and load with
// extension, sticky misaligned flag, and the MEM/WB pipeline register.
module memory_access
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_halt,
    input  logic                  i_ctl_MEM_mem_read_MEM,
    input  logic                  i_ctl_MEM_mem_write_MEM,
    input  logic                  i_ctl_MEM_unsigned_MEM,
    input  logic [1:0]            i_ctl_MEM_data_width_MEM,
    input  logic                  i_ctl_WB_mem_to_reg_MEM,
    input  logic                  i_ctl_WB_reg_write_MEM,
    input  logic [31:0]           i_ALU_result,
    input  logic [31:0]           i_data_to_write,
    input  logic [4:0]            i_reg_dest,
    input  logic [ADDR_WIDTH-1:0] i_debug_addr,
    output logic [31:0]           o_MEM_ALU_result,
    output logic                  o_ctl_WB_mem_to_reg_WB,
    output logic                  o_ctl_WB_reg_write_WB,
    output logic [31:0]           o_read_data,
    output logic [31:0]           o_ALU_result_WB,
    output logic [4:0]            o_reg_dest_WB,
    output logic                  o_misaligned,
    output logic [31:0]           o_debug_data
);

    logic [1:0]            lane;
    logic [1:0]            width;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  aligned;
    logic                  access;
    logic [3:0]            byte_en;
    logic [31:0]           wdata_lanes;
    logic [31:0]           mem_word;
    logic [31:0]           shifted;
    logic [31:0]           load_ext;

    logic [31:0] read_data_d, read_data_q;
    logic [31:0] alu_wb_q;
    logic [4:0]  reg_dest_q;
    logic        mem_to_reg_q;
    logic        reg_write_q;
    logic        misaligned_d, misaligned_q;

    assign lane     = i_ALU_result[1:0];
    assign width    = i_ctl_MEM_data_width_MEM;
    assign word_idx = i_ALU_result[ADDR_WIDTH+1:2];
    assign aligned  = is_aligned(width, lane);
    assign access   = i_ctl_MEM_mem_read_MEM | i_ctl_MEM_mem_write_MEM;
    assign byte_en  = (i_ctl_MEM_mem_write_MEM && aligned && !i_halt)
                      ? byte_enable(width, lane) : 4'b0000;

    // Store data is replicated across lanes; byte enables pick the target lane(s).
    always_comb begin
        case (width)
            WIDTH_BYTE: wdata_lanes = {4{i_data_to_write[7:0]}};
            WIDTH_HALF: wdata_lanes = {2{i_data_to_write[15:0]}};
            default:    wdata_lanes = i_data_to_write;
        endcase
    end

    data_memory #(.ADDR_WIDTH(ADDR_WIDTH)) u_data_memory (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_byte_en    (byte_en),
        .i_addr       (word_idx),
        .i_wdata      (wdata_lanes),
        .o_rdata      (mem_word),
        .i_debug_addr (i_debug_addr),
        .o_debug_data (o_debug_data)
    );

    assign shifted = mem_word >> {lane, 3'b000};

    always_comb begin
        case (width)
            WIDTH_BYTE: load_ext = i_ctl_MEM_unsigned_MEM ? {24'b0, shifted[7:0]}
                                                          : {{24{shifted[7]}}, shifted[7:0]};
            WIDTH_HALF: load_ext = i_ctl_MEM_unsigned_MEM ? {16'b0, shifted[15:0]}
                                                          : {{16{shifted[15]}}, shifted[15:0]};
            default:    load_ext = mem_word;
        endcase
    end

    // A simultaneous read+write is treated as a store with no load data.
    assign read_data_d  = (i_ctl_MEM_mem_read_MEM && !i_ctl_MEM_mem_write_MEM && aligned)
                          ? load_ext : 32'b0;
    assign misaligned_d = misaligned_q | (access & ~aligned);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            read_data_q  <= '0;
            alu_wb_q     <= '0;
            reg_dest_q   <= '0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            misaligned_q <= 1'b0;
        end else if (!i_halt) begin
            read_data_q  <= read_data_d;
            alu_wb_q     <= i_ALU_result;
            reg_dest_q   <= i_reg_dest;
            mem_to_reg_q <= i_ctl_WB_mem_to_reg_MEM;
            reg_write_q  <= i_ctl_WB_reg_write_MEM;
            misaligned_q <= misaligned_d;
        end
    end

    assign o_MEM_ALU_result       = i_ALU_result;
    assign o_read_data            = read_data_q;
    assign o_ALU_result_WB        = alu_wb_q;
    assign o_reg_dest_WB          = reg_dest_q;
    assign o_ctl_WB_mem_to_reg_WB = mem_to_reg_q;
    assign o_ctl_WB_reg_write_WB  = reg_write_q;
    assign o_misaligned           = misaligned_q;

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: table of MEM-stage operations with expected
// MEM/WB results checked through a scoreboard, plus halt/wrap/reset sequences.
module tb_memory_access;

    logic        i_clk;
    logic        i_reset;
    logic        i_halt;
    logic        rd, wr, uns, m2r, rw;
    logic [1:0]  w;
    logic [31:0] alu, wdata;
    logic [4:0]  dest;
    logic [7:0]  dbg_addr;

    logic [31:0] o_MEM_ALU_result, o_read_data, o_ALU_result_WB, o_debug_data;
    logic        o_ctl_WB_mem_to_reg_WB, o_ctl_WB_reg_write_WB, o_misaligned;
    logic [4:0]  o_reg_dest_WB;

    int total = 0;
    int bad   = 0;

    // {misaligned, mem_to_reg, reg_write, reg_dest, alu_result, read_data}
    logic [71:0] exp_q[$];

    typedef struct {
        logic        rd, wr, uns;
        logic [1:0]  w;
        logic [31:0] addr, wdata;
        logic [4:0]  dest;
        logic        m2r, rw;
        logic [31:0] exp_rd;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[$];

    memory_access #(.ADDR_WIDTH(8)) dut (
        .i_clk                    (i_clk),
        .i_reset                  (i_reset),
        .i_halt                   (i_halt),
        .i_ctl_MEM_mem_read_MEM   (rd),
        .i_ctl_MEM_mem_write_MEM  (wr),
        .i_ctl_MEM_unsigned_MEM   (uns),
        .i_ctl_MEM_data_width_MEM (w),
        .i_ctl_WB_mem_to_reg_MEM  (m2r),
        .i_ctl_WB_reg_write_MEM   (rw),
        .i_ALU_result             (alu),
        .i_data_to_write          (wdata),
        .i_reg_dest               (dest),
        .i_debug_addr             (dbg_addr),
        .o_MEM_ALU_result         (o_MEM_ALU_result),
        .o_ctl_WB_mem_to_reg_WB   (o_ctl_WB_mem_to_reg_WB),
        .o_ctl_WB_reg_write_WB    (o_ctl_WB_reg_write_WB),
        .o_read_data              (o_read_data),
        .o_ALU_result_WB          (o_ALU_result_WB),
        .o_reg_dest_WB            (o_reg_dest_WB),
        .o_misaligned             (o_misaligned),
        .o_debug_data             (o_debug_data)
    );

    // Clock / reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_wb(input string tag, input logic [31:0] e_rd, input logic [31:0] e_alu,
                          input logic [4:0] e_dest, input logic e_m2r, input logic e_rw,
                          input logic e_mis);
        chk({tag, ".read_data"}, o_read_data, e_rd);
        chk({tag, ".alu_wb"}, o_ALU_result_WB, e_alu);
        chk({tag, ".reg_dest"}, {27'b0, o_reg_dest_WB}, {27'b0, e_dest});
        chk({tag, ".mem_to_reg"}, {31'b0, o_ctl_WB_mem_to_reg_WB}, {31'b0, e_m2r});
        chk({tag, ".reg_write"}, {31'b0, o_ctl_WB_reg_write_WB}, {31'b0, e_rw});
        chk({tag, ".misaligned"}, {31'b0, o_misaligned}, {31'b0, e_mis});
    endtask

    function automatic vec_t mk(input logic r, input logic wrt, input logic u, input logic [1:0] wd,
                                input logic [31:0] a, input logic [31:0] d, input logic [4:0] ds,
                                input logic mr, input logic rwr, input logic [31:0] er,
                                input logic em);
        vec_t v;
        v.rd = r; v.wr = wrt; v.uns = u; v.w = wd; v.addr = a; v.wdata = d;
        v.dest = ds; v.m2r = mr; v.rw = rwr; v.exp_rd = er; v.exp_mis = em;
        return v;
    endfunction

    // Driver: called at a falling edge, result sampled at the next falling edge.
    task automatic drive(input logic r, input logic wrt, input logic u, input logic [1:0] wd,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] ds,
                         input logic mr, input logic rwr);
        rd = r; wr = wrt; uns = u; w = wd; alu = a; wdata = d; dest = ds; m2r = mr; rw = rwr;
    endtask

    task automatic debug_chk(input string name, input logic [7:0] idx, input logic [31:0] exp);
        dbg_addr = idx;
        #1;
        chk(name, o_debug_data, exp);
    endtask

    initial begin
        logic [71:0] e;
        i_reset = 1'b1; i_halt = 1'b0; dbg_addr = '0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // expected {mem_read, mem_write, unsigned, width, addr, wdata, dest, m2r, rw, read_data, misaligned}
        vecs.push_back(mk(0, 1, 0, 2'd2, 32'h10, 32'hDEADBEEF, 5'd3, 0, 0, 32'h0, 0));
        vecs.push_back(mk(1, 0, 0, 2'd2, 32'h10, 32'h0, 5'd4, 1, 1, 32'hDEADBEEF, 0));
        vecs.push_back(mk(1, 0, 0, 2'd0, 32'h11, 32'h0, 5'd5, 1, 1, 32'hFFFFFFBE, 0));
        vecs.push_back(mk(1, 0, 1, 2'd0, 32'h11, 32'h0, 5'd6, 1, 1, 32'h000000BE, 0));
        vecs.push_back(mk(1, 0, 0, 2'd1, 32'h12, 32'h0, 5'd7, 1, 1, 32'hFFFFDEAD, 0));
        vecs.push_back(mk(0, 1, 0, 2'd0, 32'h13, 32'hFFFFFF5A, 5'd8, 0, 0, 32'h0, 0));
        vecs.push_back(mk(1, 0, 0, 2'd2, 32'h10, 32'h0, 5'd9, 1, 1, 32'h5AADBEEF, 0));
        vecs.push_back(mk(1, 0, 1, 2'd1, 32'h10, 32'h0, 5'd10, 1, 1, 32'h0000BEEF, 0));
        vecs.push_back(mk(1, 0, 0, 2'd1, 32'h10, 32'h0, 5'd11, 1, 1, 32'hFFFFBEEF, 0));
        vecs.push_back(mk(1, 0, 0, 2'd0, 32'h13, 32'h0, 5'd12, 1, 1, 32'h0000005A, 0));
        vecs.push_back(mk(0, 0, 0, 2'd2, 32'hCAFE0000, 32'h55, 5'd13, 0, 1, 32'h0, 0));
        vecs.push_back(mk(0, 1, 0, 2'd3, 32'h14, 32'h01020304, 5'd14, 0, 0, 32'h0, 0));
        vecs.push_back(mk(1, 0, 1, 2'd0, 32'h16, 32'h0, 5'd15, 1, 1, 32'h00000002, 0));
        vecs.push_back(mk(1, 1, 0, 2'd2, 32'h18, 32'h11111111, 5'd16, 1, 1, 32'h0, 0));
        vecs.push_back(mk(1, 0, 0, 2'd2, 32'h18, 32'h0, 5'd17, 1, 1, 32'h11111111, 0));
        vecs.push_back(mk(0, 1, 0, 2'd1, 32'h21, 32'hBBBB, 5'd18, 0, 0, 32'h0, 1));
        vecs.push_back(mk(1, 0, 0, 2'd2, 32'h20, 32'h0, 5'd19, 1, 1, 32'h0, 1));
        vecs.push_back(mk(1, 0, 0, 2'd2, 32'h12, 32'h0, 5'd20, 1, 1, 32'h0, 1));
        vecs.push_back(mk(1, 0, 1, 2'd1, 32'h15, 32'h0, 5'd21, 1, 1, 32'h0, 1));

        repeat (2) @(negedge i_clk);
        chk_wb("reset", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        debug_chk("reset.debug_idx4", 8'd4, 32'h0);
        i_reset = 1'b0;

        // Table-driven vectors through the scoreboard
        foreach (vecs[k]) begin
            drive(vecs[k].rd, vecs[k].wr, vecs[k].uns, vecs[k].w, vecs[k].addr,
                  vecs[k].wdata, vecs[k].dest, vecs[k].m2r, vecs[k].rw);
            exp_q.push_back({vecs[k].exp_mis, vecs[k].m2r, vecs[k].rw, vecs[k].dest,
                             vecs[k].addr, vecs[k].exp_rd});
            #1;
            chk($sformatf("vec%0d.fwd_alu", k), o_MEM_ALU_result, vecs[k].addr);
            @(negedge i_clk);
            if (exp_q.size() == 0) begin
                chk($sformatf("vec%0d.queue_empty", k), 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk_wb($sformatf("vec%0d", k), e[31:0], e[63:32], e[68:64], e[70], e[69], e[71]);
            end
        end
        debug_chk("debug_idx4", 8'd4, 32'h5AADBEEF);
        debug_chk("debug_idx5", 8'd5, 32'h01020304);
        debug_chk("debug_idx6", 8'd6, 32'h11111111);
        debug_chk("debug_idx8_misaligned_store", 8'd8, 32'h0);

        // Halt: store and WB latch frozen, forwarding and debug stay live
        i_halt = 1'b1;
        drive(0, 1, 0, 2'd2, 32'h30, 32'h12345678, 5'd7, 0, 0);
        @(negedge i_clk);
        chk_wb("halt", 32'h0, 32'h15, 5'd21, 1'b1, 1'b1, 1'b1);
        chk("halt.fwd_alu", o_MEM_ALU_result, 32'h30);
        debug_chk("halt.debug_idx12", 8'd12, 32'h0);
        i_halt = 1'b0;
        @(negedge i_clk);
        chk_wb("unhalt", 32'h0, 32'h30, 5'd7, 1'b0, 1'b0, 1'b1);
        debug_chk("unhalt.debug_idx12", 8'd12, 32'h12345678);

        // Address wrap: 0x404 maps to word index 1
        drive(0, 1, 0, 2'd2, 32'h404, 32'hA5A5A5A5, 5'd1, 0, 0);
        @(negedge i_clk);
        debug_chk("wrap.debug_idx1", 8'd1, 32'hA5A5A5A5);
        drive(1, 0, 0, 2'd2, 32'h4, 32'h0, 5'd2, 1, 1);
        @(negedge i_clk);
        chk("wrap.load_idx1", o_read_data, 32'hA5A5A5A5);

        // Asynchronous reset in the middle of a cycle
        drive(0, 1, 0, 2'd2, 32'h4, 32'hFFFFFFFF, 5'd9, 1, 1);
        #2;
        i_reset = 1'b1;
        #1;
        chk_wb("async_reset", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        debug_chk("async_reset.debug_idx1", 8'd1, 32'h0);
        debug_chk("async_reset.debug_idx4", 8'd4, 32'h0);
        @(negedge i_clk);
        debug_chk("reset_held.debug_idx1", 8'd1, 32'h0);
        i_reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_access.md
# memory_access

Pipeline MEM stage of the MIPS core: consumes the EX/MEM outputs of `instruction_exec` (ALU result, store data, destination register, MEM/WB control) and performs byte/halfword/word loads and stores against a byte-addressed data memory. It registers results into the MEM/WB latch for write-back. It also exposes the current MEM-stage ALU result combinationally for EX forwarding, and provides a read-only debug port for the debug unit.

## Interface
- `ADDR_WIDTH`, 8: word-index width; memory holds 2^ADDR_WIDTH 32-bit words.
- `i_clk`  in  1  clock; all state updates on rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_halt`  in  1  freeze: no memory write, MEM/WB latch holds.
- `i_ctl_MEM_mem_read_MEM`  in  1  load enable.
- `i_ctl_MEM_mem_write_MEM`  in  1  store enable.
- `i_ctl_MEM_unsigned_MEM`  in  1  1 = zero-extend load, 0 = sign-extend.
- `i_ctl_MEM_data_width_MEM`  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- `i_ctl_WB_mem_to_reg_MEM`  in  1  passed to WB.
- `i_ctl_WB_reg_write_MEM`  in  1  passed to WB.
- `i_ALU_result`  in  32  byte address for loads/stores; passthrough value otherwise.
- `i_data_to_write`  in  32  store data (low bits used for byte/half).
- `i_reg_dest`  in  5  destination register.
- `i_debug_addr`  in  ADDR_WIDTH  debug word index.
- `o_MEM_ALU_result`  out  32  combinational copy of `i_ALU_result` (to EX forwarding mux).
- `o_ctl_WB_mem_to_reg_WB`  out  1  registered.
- `o_ctl_WB_reg_write_WB`  out  1  registered.
- `o_read_data`  out  32  registered extended load data.
- `o_ALU_result_WB`  out  32  registered ALU result.
- `o_reg_dest_WB`  out  5  registered destination.
- `o_misaligned`  out  1  sticky misaligned-access flag.
- `o_debug_data`  out  32  combinational full word at `i_debug_addr`.

## Operation
- Address: word index = `i_ALU_result[ADDR_WIDTH+1:2]`; upper bits ignored (wrap-around); lane = `i_ALU_result[1:0]`, little-endian (lane 0 = bits 7:0).
- Alignment: half requires bit0 = 0; word requires bits 1:0 = 00. Misaligned access: store suppressed, load data = 0, `o_misaligned` set and held until reset. WB controls still latched unchanged.
- Store: byte writes `i_data_to_write[7:0]` into addressed lane; half writes `[15:0]` into lanes {1,0} or {3,2}; word writes all lanes; other bytes untouched.
- Load: select lane(s), sign- or zero-extend per `i_ctl_MEM_unsigned_MEM`; word ignores unsigned.
- `mem_read` = 0: `o_read_data` latches 0. `mem_read` and `mem_write` both 1: illegal. Store executes, load data = 0.
- Halt: no write, no `o_misaligned` update, all MEM/WB outputs hold. `o_MEM_ALU_result` and debug port remain live.
- Reset: all registered outputs 0, `o_misaligned` 0, entire memory cleared to 0.

## Timing
- Store commits on the rising edge where `mem_write` = 1, aligned, and `i_halt` = 0.
- Load reads the array combinationally and is captured into `o_read_data` at the same edge: 1-cycle latency, input cycle N → output valid cycle N+1.
- A store at edge N followed by a load of the same address in cycle N+1 returns the new data.
- `o_debug_data` reflects a store from the cycle after its commit edge.
- Reset asserted mid-operation: outputs and memory clear immediately (asynchronous), no write that cycle.

## Structure
- Package `mem_pkg`: width encodings `WIDTH_BYTE`/`WIDTH_HALF`/`WIDTH_WORD`, and a byte-enable computation function.
- Sub-module `data_memory`: 2^ADDR_WIDTH × 32 RAM with 4-bit byte-enable synchronous write, async clear, and two combinational read ports (pipeline, debug).
- Top-level holds alignment check, lane select/extension, and the MEM/WB register.

## Test plan
- Store word 0xDEADBEEF at address 0x10, then load word at 0x10 → `o_read_data` = 0xDEADBEEF one cycle later; `o_debug_data` at index 4 = 0xDEADBEEF.
- After that store, load byte at 0x11, signed → 0xFFFFFFBE. Repeat unsigned → 0x000000BE. Load half at 0x12, signed → 0xFFFFDEAD.
- Store byte 0x5A at 0x13 → word at index 4 reads 0x5AADBEEF.
- Store half at 0x21 → no write, word at index 8 stays 0, `o_misaligned` = 1 and stays 1 across subsequent aligned accesses until reset.
- `i_halt` = 1 during a store of 0x12345678 to 0x30 with new WB controls/`i_reg_dest` = 7 → memory unchanged, all WB outputs hold previous values. Deasserting halt lets the store commit.
- Address 0x400 + 0x04 with `ADDR_WIDTH` = 8 → wraps to index 1. Async reset mid-stream → all outputs 0 and index 1 reads 0.
